lsu_rv64: RTL and testbench
===========================

Name: lsu_rv64

Overview:
- Load/store unit directly downstream of the Zba execute ALU; consumes ALUResult as the effective address.
- Drives a 64-bit data-memory bus with a req/gnt/rvalid handshake. Performs byte-lane alignment and load sign/zero extension.
- Stalls the pipeline for the duration of each access and flags misaligned accesses without touching the bus.

Parameters:
TIMEOUT_CYCLES, 255, bus wait-cycle limit before BusError (used only with LSU_BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ValidE  in  1  memory op valid from EX
MemRead  in  1  load request
MemWrite  in  1  store request
Funct3  in  3  0=B 1=H 2=W 3=D 4=BU 5=HU 6=WU
ALUResult  in  64  effective byte address
WriteData  in  64  store data (rs2)
Stall  out  1  hold upstream stages
LoadResult  out  64  extended load data
LoadValid  out  1  LoadResult valid, one-cycle pulse
Misaligned  out  1  misaligned/illegal access trap, one-cycle pulse
BusError  out  1  bus timeout, one-cycle pulse
DMemReq  out  1  bus request
DMemWe  out  1  1=write
DMemAddr  out  64  doubleword-aligned address {addr[63:3],3'b000}
DMemBe  out  8  byte enables
DMemWData  out  64  lane-shifted write data
DMemGnt  in  1  request accepted
DMemRValid  in  1  read data valid
DMemRData  in  64  read data

Behaviour:
- Reset: async on rst_n=0. State=IDLE. All outputs and capture registers are 0.
- start = ValidE & (MemRead | MemWrite). If MemRead and MemWrite are both 1, the op is a load and no write occurs.
- Misaligned condition:
  - H/HU: addr[0]≠0.
  - W/WU: addr[1:0]≠0.
  - D: addr[2:0]≠0.
  - Funct3=7 is always misaligned. Stores with Funct3 4–6 are also misaligned (illegal).
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - start & misaligned: Misaligned pulses the next cycle. No bus access. Stay IDLE. Stall=0.
  - start & aligned: capture address, data, Funct3 and direction. Go to REQ. Stall=1 in this cycle.
- REQ:
  - DMemReq=1. DMemWe, DMemAddr, DMemBe and DMemWData are driven from the capture registers and held stable until DMemGnt.
  - On DMemGnt: a store goes to DONE; a load goes to WAIT.
  - DMemRValid is ignored in REQ.
- WAIT:
  - DMemReq=0.
  - On DMemRValid: register the extended data into LoadResult and go to DONE.
  - DMemGnt is ignored in WAIT.
- DONE: Stall=0. LoadValid=1 only for loads. Go to IDLE. No new op is accepted in DONE.
- Stall = (IDLE & start & aligned) | REQ | WAIT. It is combinational.
- Minimum latency, load: accept at c0, gnt at c1, rvalid at c2, LoadValid at c3. Store: accept at c0, gnt at c1, DONE at c2.
- Lanes, with off = addr[2:0]:
  - DMemBe = size mask (B=0x01, H=0x03, W=0x0F, D=0xFF) << off.
  - DMemWData = WriteData << 8*off.
  - Load data = DMemRData >> 8*off. Sign-extend for B/H/W; zero-extend for BU/HU/WU; D is passed through.
- LoadResult holds its value until the next load completes.
- Reset mid-access: abort immediately. A late DMemRValid/DMemGnt arriving in IDLE is ignored.
- Upstream must hold its inputs stable while Stall=1. Inputs are don't-care outside IDLE.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ or WAIT and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES: BusError pulses in the DONE cycle and LoadValid=0. LoadResult is unchanged and no bus state is retained.
- Not defined: BusError is tied 0. REQ and WAIT may wait indefinitely.

Test Plan:
- LD at 0x1000, gnt immediate, rvalid next cycle with RData=0x1122334455667788 -> DMemBe=0xFF. LoadResult=0x1122334455667788 with LoadValid at c3. Stall high c0–c2.
- LB at 0x1003, RData=0x00000000_80000000 -> DMemBe=0x08, LoadResult=0xFFFFFFFFFFFFFF80. LBU at the same address -> 0x0000000000000080.
- SH at 0x2006, WriteData=0xABCD, gnt delayed 3 cycles -> DMemBe=0xC0, DMemWData=0xABCD_0000_0000_0000 held stable. DMemWe=1. Stall high until DONE.
- LW at 0x3002 -> Misaligned pulse next cycle, no DMemReq, Stall=0. Funct3=7 load -> same response.
- rst_n low while in WAIT, then rvalid arrives after reset release -> outputs 0, state IDLE, LoadValid never asserts.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with gnt never asserted -> BusError pulse after 4 REQ cycles. LoadValid=0, then returns to IDLE.

Source files
------------

// File: rtl/lsu_rv64.sv
// lsu_rv64: RV64 load/store unit sitting behind the execute ALU.
// Takes ALUResult as the effective byte address, runs one access at a time
// over a 64-bit req/gnt/rvalid data bus, aligns byte lanes, and sign/zero
// extends load data. Misaligned or illegal accesses trap without a bus cycle.
// Optional feature: define LSU_BUS_TIMEOUT_EN to abort an access with a
// BusError pulse after TIMEOUT_CYCLES cycles in REQ or WAIT.
`timescale 1ns/1ps

module lsu_rv64 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidE,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [63:0] ALUResult,
  input  logic [63:0] WriteData,
  output logic        Stall,
  output logic [63:0] LoadResult,
  output logic        LoadValid,
  output logic        Misaligned,
  output logic        BusError,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [63:0] DMemAddr,
  output logic [7:0]  DMemBe,
  output logic [63:0] DMemWData,
  input  logic        DMemGnt,
  input  logic        DMemRValid,
  input  logic [63:0] DMemRData
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // At least 8 bits, wide enough to hold TIMEOUT_CYCLES.
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  state_t           state;
  logic             start;
  logic             misaligned;
  logic             accept;
  logic [2:0]       off;
  logic [7:0]       be_next;
  logic [63:0]      wdata_next;
  logic             load_q;
  logic [2:0]       funct3_q;
  logic [2:0]       off_q;
  logic [63:0]      rdata_sh;
  logic [63:0]      load_ext;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;

  // Byte-enable pattern for an access of the given size, before lane shift.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // A load wins when both MemRead and MemWrite are set.
  assign start  = ValidE & (MemRead | MemWrite);
  assign off    = ALUResult[2:0];
  assign accept = (state == IDLE) & start & ~misaligned;

  // Stall is combinational so the accepting cycle already holds upstream.
  assign Stall = accept | (state == REQ) | (state == WAIT);

  assign be_next    = size_mask(Funct3[1:0]) << off;
  assign wdata_next = WriteData << {off, 3'b000};
  assign rdata_sh   = DMemRData >> {off_q, 3'b000};

  // Alignment check by access size; Funct3=7 and unsigned-store encodings are illegal.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    misaligned = 1'b0;
    case (Funct3)
      3'd1, 3'd5: misaligned = ALUResult[0];
      3'd2, 3'd6: misaligned = |ALUResult[1:0];
      3'd3:       misaligned = |ALUResult[2:0];
      3'd7:       misaligned = 1'b1;
      default:    misaligned = 1'b0;
    endcase
    if (!MemRead && Funct3[2]) misaligned = 1'b1;
  end

  // Sign/zero extension of the lane-shifted read data by captured Funct3.
  always_comb begin
    load_ext = rdata_sh;
    case (funct3_q)
      3'd0:    load_ext = {{56{rdata_sh[7]}},  rdata_sh[7:0]};
      3'd1:    load_ext = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      3'd2:    load_ext = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      3'd4:    load_ext = {56'd0, rdata_sh[7:0]};
      3'd5:    load_ext = {48'd0, rdata_sh[15:0]};
      3'd6:    load_ext = {32'd0, rdata_sh[31:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  // Wait-cycle counter: cleared on entry to REQ or WAIT, counts while there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (accept || ((state == REQ) && DMemGnt)) begin
      wait_cnt <= '0;
    end else if ((state == REQ) || (state == WAIT)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Timeout fires on the last allowed cycle unless the bus responds in it.
  assign timeout = TIMEOUT_EN &&
                   (((state == REQ) && !DMemGnt) || ((state == WAIT) && !DMemRValid)) &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Access FSM with registered bus signals and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every state and capture register is reset so an aborted
      // access leaves nothing behind for a late gnt/rvalid to act on.
      state      <= IDLE;
      load_q     <= 1'b0;
      funct3_q   <= 3'd0;
      off_q      <= 3'd0;
      LoadResult <= '0;
      LoadValid  <= 1'b0;
      Misaligned <= 1'b0;
      BusError   <= 1'b0;
      DMemReq    <= 1'b0;
      DMemWe     <= 1'b0;
      DMemAddr   <= '0;
      DMemBe     <= '0;
      DMemWData  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from the same
      // pre-edge values regardless of statement order.
      LoadValid  <= 1'b0;
      Misaligned <= 1'b0;
      BusError   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && misaligned) begin
            Misaligned <= 1'b1;
          end else if (start) begin
            state     <= REQ;
            load_q    <= MemRead;
            funct3_q  <= Funct3;
            off_q     <= off;
            DMemReq   <= 1'b1;
            DMemWe    <= ~MemRead;
            DMemAddr  <= {ALUResult[63:3], 3'b000};
            DMemBe    <= be_next;
            DMemWData <= wdata_next;
          end
        end
        REQ: begin
          if (DMemGnt || timeout) begin
            DMemReq   <= 1'b0;
            DMemWe    <= 1'b0;
            DMemAddr  <= '0;
            DMemBe    <= '0;
            DMemWData <= '0;
            if (DMemGnt) begin
              state <= load_q ? WAIT : DONE;
            end else begin
              BusError <= 1'b1;
              state    <= DONE;
            end
          end
        end
        WAIT: begin
          if (DMemRValid) begin
            LoadResult <= load_ext;
            LoadValid  <= 1'b1;
            state      <= DONE;
          end else if (timeout) begin
            BusError <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rv64.sv
// tb_lsu_rv64: directed bench for lsu_rv64. A byte-level reference model
// produces expected lanes and load results; a per-cycle compare process
// checks control outputs and bus fields, and literal expectations per vector
// pin the model.
`timescale 1ns/1ps

module tb_lsu_rv64;

  logic        clk;
  logic        rst_n;
  logic        ValidE, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [63:0] ALUResult, WriteData;
  logic        Stall, LoadValid, Misaligned, BusError;
  logic [63:0] LoadResult;
  logic        DMemReq, DMemWe;
  logic [63:0] DMemAddr, DMemWData;
  logic [7:0]  DMemBe;
  logic        DMemGnt, DMemRValid;
  logic [63:0] DMemRData;

  int n_checks = 0;
  int n_fail   = 0;

  // Expectations for the current cycle, written by the driver.
  logic        chk_en   = 1'b0;
  logic        bus_zero = 1'b0;
  logic        exp_stall, exp_req, exp_lv, exp_mis, exp_berr, exp_we;
  logic [63:0] exp_addr, exp_wd, lr_model;
  logic [7:0]  exp_be;

  typedef struct {
    logic        ld;
    logic        both;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    int          gd;
    int          rd;
    logic [63:0] rdata;
    logic [7:0]  lit_be;
    logic [63:0] lit_wd;
    logic [63:0] lit_res;
  } vec_t;

  vec_t vecs[$];

  lsu_rv64 #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .MemRead(MemRead),
    .MemWrite(MemWrite), .Funct3(Funct3), .ALUResult(ALUResult),
    .WriteData(WriteData), .Stall(Stall), .LoadResult(LoadResult),
    .LoadValid(LoadValid), .Misaligned(Misaligned), .BusError(BusError),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemBe(DMemBe),
    .DMemWData(DMemWData), .DMemGnt(DMemGnt), .DMemRValid(DMemRValid),
    .DMemRData(DMemRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic model_mis(input logic ld, input logic [2:0] f3, input logic [63:0] addr);
    int sz;
    sz = size_bytes(f3);
    if (f3 == 3'd7) return 1'b1;
    if (!ld && f3 >= 3'd4) return 1'b1;
    return (int'(addr[2:0]) % sz) != 0;
  endfunction

  function automatic logic [7:0] model_be(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] be;
    be = '0;
    for (int i = 0; i < size_bytes(f3); i++) be[int'(off) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [2:0] off);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i + int'(off) < 8; i++) o[8*(i + int'(off)) +: 8] = wd[8*i +: 8];
    return o;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [2:0] off,
                                             input logic [63:0] rd);
    logic [63:0] v;
    int sz;
    sz = size_bytes(f3);
    v  = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(i + int'(off)) +: 8];
    if (f3 < 3'd3 && v[8*sz - 1])
      for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic vec_t mk(input logic ld, input logic both, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wd,
                              input int gd, input int rd, input logic [63:0] rdata,
                              input logic [7:0] lit_be, input logic [63:0] lit_wd,
                              input logic [63:0] lit_res);
    vec_t v;
    v.ld = ld; v.both = both; v.f3 = f3; v.addr = addr; v.wd = wd; v.gd = gd;
    v.rd = rd; v.rdata = rdata; v.lit_be = lit_be; v.lit_wd = lit_wd; v.lit_res = lit_res;
    return v;
  endfunction

  task automatic set_exp(input logic st, input logic rq, input logic lv,
                         input logic ms, input logic be);
    exp_stall = st; exp_req = rq; exp_lv = lv; exp_mis = ms; exp_berr = be;
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("Stall",      Stall,      exp_stall);
        check("DMemReq",    DMemReq,    exp_req);
        check("LoadValid",  LoadValid,  exp_lv);
        check("Misaligned", Misaligned, exp_mis);
        check("BusError",   BusError,   exp_berr);
        check("LoadResult", LoadResult, lr_model);
        if (exp_req) begin
          check("DMemAddr", DMemAddr, exp_addr);
          check("DMemBe",   DMemBe,   exp_be);
          check("DMemWe",   DMemWe,   exp_we);
          if (exp_we) check("DMemWData", DMemWData, exp_wd);
        end else if (bus_zero) begin
          check("DMemAddr_zero",  DMemAddr,  64'd0);
          check("DMemBe_zero",    DMemBe,    64'd0);
          check("DMemWe_zero",    DMemWe,    64'd0);
          check("DMemWData_zero", DMemWData, 64'd0);
        end
      end
    end
  end

  // ---------------- one transaction ----------------
  task automatic do_op(input vec_t v);
    logic mis;
    mis      = model_mis(v.ld, v.f3, v.addr);
    exp_addr = {v.addr[63:3], 3'b000};
    exp_be   = model_be(v.f3, v.addr[2:0]);
    exp_wd   = model_wdata(v.wd, v.addr[2:0]);
    exp_we   = !v.ld;
    // accept / reject cycle
    @(posedge clk); #1;
    ValidE = 1'b1; MemRead = v.ld; MemWrite = v.both | !v.ld;
    Funct3 = v.f3; ALUResult = v.addr; WriteData = v.wd;
    DMemGnt = 1'b0; DMemRValid = 1'b0;
    set_exp(!mis, 1'b0, 1'b0, 1'b0, 1'b0);
    if (mis) begin
      @(posedge clk); #1;
      ValidE = 1'b0;
      set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      return;
    end
    // REQ: stray rvalid is offered while waiting for gnt
    for (int k = 0; k <= v.gd; k++) begin
      @(posedge clk); #1;
      DMemGnt    = (k == v.gd);
      DMemRValid = (k != v.gd);
      DMemRData  = 64'hFFFF_FFFF_FFFF_FFFF;
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 0) begin
        @(negedge clk);
        check("lit_be", DMemBe, v.lit_be);
        if (!v.ld) check("lit_wd", DMemWData, v.lit_wd);
      end
    end
    // WAIT: stray gnt is offered while waiting for rvalid
    if (v.ld) begin
      for (int j = 0; j <= v.rd; j++) begin
        @(posedge clk); #1;
        DMemGnt    = (j != v.rd);
        DMemRValid = (j == v.rd);
        DMemRData  = (j == v.rd) ? v.rdata : 64'h5555_5555_5555_5555;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    // DONE
    @(posedge clk); #1;
    ValidE = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    DMemGnt = 1'b0; DMemRValid = 1'b0;
    if (v.ld) lr_model = model_load(v.f3, v.addr[2:0], v.rdata);
    set_exp(1'b0, 1'b0, v.ld, 1'b0, 1'b0);
    if (v.ld) begin
      @(negedge clk);
      check("lit_res", LoadResult, v.lit_res);
    end
  endtask

  // Watchdog: the bench must always terminate.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; ValidE = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
    ALUResult = '0; WriteData = '0; DMemGnt = 1'b0; DMemRValid = 1'b0; DMemRData = '0;
    exp_addr = '0; exp_be = '0; exp_wd = '0; exp_we = 1'b0; lr_model = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_zero = 1'b1;
    chk_en   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus_zero = 1'b0;

    //           ld    both  f3    addr          wd                     gd rd rdata                  be     lit_wd                 lit_res
    vecs.push_back(mk(1'b1, 1'b0, 3'd3, 64'h1000, 64'h0,                 0, 0, 64'h1122334455667788, 8'hFF, 64'h0,                 64'h1122334455667788));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 64'h1003, 64'h0,                 0, 0, 64'h0000000080000000, 8'h08, 64'h0,                 64'hFFFFFFFFFFFFFF80));
    vecs.push_back(mk(1'b1, 1'b0, 3'd4, 64'h1003, 64'h0,                 0, 0, 64'h0000000080000000, 8'h08, 64'h0,                 64'h0000000000000080));
    vecs.push_back(mk(1'b0, 1'b0, 3'd1, 64'h2006, 64'hABCD,              3, 0, 64'h0,                8'hC0, 64'hABCD000000000000,  64'h0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd2, 64'h3002, 64'h0,                 0, 0, 64'h0,                8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd7, 64'h3000, 64'h0,                 0, 0, 64'h0,                8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd1, 64'h100A, 64'h0,                 0, 1, 64'hDEADBEEF87654321, 8'h0C, 64'h0,                 64'hFFFFFFFFFFFF8765));
    vecs.push_back(mk(1'b1, 1'b0, 3'd5, 64'h1006, 64'h0,                 0, 0, 64'hDEADBEEF87654321, 8'hC0, 64'h0,                 64'h000000000000DEAD));
    vecs.push_back(mk(1'b1, 1'b0, 3'd2, 64'h1004, 64'h0,                 0, 0, 64'hDEADBEEF87654321, 8'hF0, 64'h0,                 64'hFFFFFFFFDEADBEEF));
    vecs.push_back(mk(1'b1, 1'b0, 3'd6, 64'h1000, 64'h0,                 0, 0, 64'hDEADBEEF87654321, 8'h0F, 64'h0,                 64'h0000000087654321));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 64'h2001, 64'h111122223333445A,  0, 0, 64'h0,                8'h02, 64'h1122223333445A00,  64'h0));
    vecs.push_back(mk(1'b0, 1'b0, 3'd3, 64'h2008, 64'hCAFEF00D12345678,  1, 0, 64'h0,                8'hFF, 64'hCAFEF00D12345678,  64'h0));
    vecs.push_back(mk(1'b0, 1'b0, 3'd2, 64'h200C, 64'h0000000089ABCDEF,  0, 0, 64'h0,                8'hF0, 64'h89ABCDEF00000000,  64'h0));
    vecs.push_back(mk(1'b1, 1'b1, 3'd2, 64'h3000, 64'hFFFFFFFFFFFFFFFF,  2, 2, 64'h0123456789ABCDEF, 8'h0F, 64'h0,                 64'hFFFFFFFF89ABCDEF));
    vecs.push_back(mk(1'b0, 1'b0, 3'd4, 64'h3000, 64'h12,                0, 0, 64'h0,                8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(1'b0, 1'b0, 3'd3, 64'h3004, 64'h12,                0, 0, 64'h0,                8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd5, 64'h3001, 64'h0,                 0, 0, 64'h0,                8'h00, 64'h0,                 64'h0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd3, 64'h5008, 64'h0,                 1, 3, 64'h0F0E0D0C0B0A0908, 8'hFF, 64'h0,                 64'h0F0E0D0C0B0A0908));

    foreach (vecs[i]) do_op(vecs[i]);

    // Reset while in WAIT, then late rvalid/gnt after release.
    @(posedge clk); #1;
    ValidE = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd3; ALUResult = 64'h6000;
    exp_addr = 64'h6000; exp_be = 8'hFF; exp_we = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    DMemGnt = 1'b1;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    DMemGnt = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0; ValidE = 1'b0; MemRead = 1'b0;
    lr_model = '0; bus_zero = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; DMemRValid = 1'b1; DMemRData = 64'hBADC0FFEE0DDF00D;
    @(posedge clk); #1;
    DMemGnt = 1'b1;
    @(posedge clk); #1;
    DMemRValid = 1'b0; DMemGnt = 1'b0;
    @(posedge clk); #1;
    bus_zero = 1'b0;

`ifdef LSU_BUS_TIMEOUT_EN
    // Load whose gnt never comes: four REQ cycles, then BusError in DONE.
    @(posedge clk); #1;
    ValidE = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd3; ALUResult = 64'h4000;
    exp_addr = 64'h4000; exp_be = 8'hFF; exp_we = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    ValidE = 1'b0; MemRead = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // A normal load after the abort paths.
    do_op(mk(1'b1, 1'b0, 3'd0, 64'h7007, 64'h0, 0, 0, 64'h7F00000000000000, 8'h80, 64'h0, 64'h000000000000007F));

    @(posedge clk); #1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
